// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read per instruction, result held for the core.
// Optional misaligned-PC trap is enabled by defining IFU_ALIGN_CHECK_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_fault,
    input  logic [XLEN-1:0] next_pc
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, valid and its payload stay unchanged until that transfer occurs.

    state_t state;
    state_t state_next;
    logic   misaligned;

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Outputs decode only the state and registers, so no imem_* or inst_ready input
    // reaches any output in the same cycle.
    assign imem_req_valid = (state == REQ) && !misaligned;
    assign imem_addr      = pc;
    assign inst_valid     = (state == VALID);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = REQ;
            REQ: begin
                if (misaligned)
                    state_next = VALID;
                else if (imem_req_ready)
                    state_next = WAIT;
            end
            WAIT:    if (imem_resp_valid) state_next = VALID;
            VALID:   if (inst_ready) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= XLEN'(NOP);
            inst_fault <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                REQ: begin
                    // A misaligned PC never reaches memory; the core sees a faulting NOP.
                    if (misaligned) begin
                        inst       <= XLEN'(NOP);
                        inst_fault <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        inst       <= imem_resp_data;
                        inst_fault <= imem_resp_err;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        pc         <= next_pc;
                        inst_fault <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: memory and core agents, address/instruction scoreboards.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic [31:0] next_pc;

    ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .inst_fault      (inst_fault),
        .next_pc         (next_pc)
    );

    always #5 clk = ~clk;

    // Scoreboards: expected fetch addresses, and expected {pc, inst, fault} per delivered instruction.
    logic [31:0] exp_addr_q[$];
    logic [64:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    // Memory agent knobs and state
    bit          pending = 0;
    int          pend_delay = 0;
    logic [31:0] pend_data;
    logic        pend_err;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          req_rand = 0;
    int          req_hold = 0;
    bit          err_rand = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_data;
    logic        ovr_err;
    int          ovr_hold = 0;

    // Core agent knobs and state
    bit          core_rand = 0;
    int          core_hold = 0;
    bit          jump_en = 0;
    logic [31:0] jump_pc;
    bit          jump_rand = 0;
    bit          mis_rand = 0;
    logic [31:0] cur_pc = RST_PC;

    // Monitor state
    int          cyc = 0;
    int          last_hs = 0;
    bit          hs_seen = 0;
    int          hs_count = 0;
    bit          lat_chk = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        prev_fault;
    logic [64:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    // Memory may only respond while a fetch is outstanding.
    always @(posedge clk) begin
        if (rst_n && imem_resp_valid)
            assert (dut.state == WAIT) else $error("protocol: response outside WAIT");
    end

    // Memory agent: decides inputs for the coming edge at each falling edge.
    initial begin
        logic [31:0] a;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            imem_resp_err   = 1'($urandom_range(0, 1));
            if (!rst_n) begin
                pending        = 0;
                imem_req_ready = 1'b0;
            end else begin
                if (pending) begin
                    if (pend_delay == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = pend_data;
                        imem_resp_err   = pend_err;
                        pending         = 0;
                    end else begin
                        pend_delay--;
                    end
                end
                if (imem_req_valid && req_hold > 0) begin
                    imem_req_ready = 1'b0;
                    req_hold--;
                end else if (req_rand) begin
                    imem_req_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    imem_req_ready = 1'b1;
                end
                if (imem_req_valid && imem_req_ready) begin
                    a = (exp_addr_q.size() > 0) ? exp_addr_q[0] : imem_addr;
                    if (ovr_en) begin
                        pend_data = ovr_data;
                        pend_err  = ovr_err;
                        core_hold = ovr_hold;
                        ovr_en    = 0;
                    end else begin
                        pend_data = mem_word(imem_addr);
                        pend_err  = err_rand && ($urandom_range(0, 7) == 0);
                    end
                    pend_delay = $urandom_range(lat_min, lat_max);
                    pending    = 1;
                    exp_q.push_back({a, pend_data, pend_err});
                end
            end
        end
    end

    // Core agent: consumes instructions and chooses the next PC.
    initial begin
        logic [31:0] rnd;
        logic [31:0] npc;
        inst_ready = 1'b0;
        next_pc    = '0;
        forever begin
            @(negedge clk);
            next_pc = $urandom;
            if (!rst_n) begin
                inst_ready = 1'b0;
            end else begin
                if (inst_valid && core_hold > 0) begin
                    inst_ready = 1'b0;
                    core_hold--;
                end else if (core_rand) begin
                    inst_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    inst_ready = 1'b1;
                end
                if (inst_valid && inst_ready) begin
                    rnd = $urandom;
                    if (jump_en) begin
                        npc     = jump_pc;
                        jump_en = 0;
                    end else if (jump_rand && rnd[3:0] == 4'd0) begin
                        npc = {4'h8, rnd[27:2], 2'b00};
                    end else if (mis_rand && rnd[3:0] == 4'd1) begin
                        npc = cur_pc + 32'd2;
                    end else begin
                        npc = cur_pc + 32'd4;
                    end
                    next_pc = npc;
                    if (npc[1:0] != 2'b00) begin
                        exp_q.push_back({npc, NOP, 1'b1});
                        cur_pc = {npc[31:2], 2'b00};
                    end else begin
                        exp_addr_q.push_back(npc);
                        cur_pc = npc;
                    end
                end
            end
        end
    end

    // Monitor: compares every observed transfer against the scoreboards.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                prev_hold = 0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL req_unexpected: got request at %h want no request", imem_addr);
                    end else begin
                        chk("imem_addr", imem_addr, exp_addr_q.pop_front());
                    end
                end
                if (!inst_valid)
                    chk("fault_clear", inst_fault, 0);
                if (inst_valid && prev_hold) begin
                    chk("inst_stable", inst, prev_inst);
                    chk("pc_stable", pc, prev_pc);
                    chk("fault_stable", inst_fault, prev_fault);
                end
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL inst_unexpected: got pc %h want no instruction", pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", pc, e[64:33]);
                        chk("inst_word", inst, e[32:1]);
                        chk("inst_fault", inst_fault, e[0]);
                    end
                    if (lat_chk && hs_seen)
                        chk("hs_gap", cyc - last_hs, 3);
                    last_hs = cyc;
                    hs_seen = 1;
                    hs_count++;
                end
                prev_hold  = inst_valid && !inst_ready;
                prev_inst  = inst;
                prev_pc    = pc;
                prev_fault = inst_fault;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, NOP);
        chk("rst_fault", inst_fault, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #2;
        exp_q.delete();
        exp_addr_q.delete();
        exp_addr_q.push_back(RST_PC);
        cur_pc  = RST_PC;
        hs_seen = 0;
        rst_n   = 1'b1;
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int target;
        int k;
        target = hs_count + n;
        k = 0;
        while (hs_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (hs_count < target) begin
            bad++;
            $display("FAIL %s: got %0d instructions want %0d (timeout)", name, hs_count - target + n, n);
        end
    endtask

    initial begin
        int k;
        // Reset values, then back-to-back fetches at minimum latency.
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals();
        lat_chk = 1;
        release_reset();
        wait_hs(5, 40, "basic");
        lat_chk = 0;

        // Request held off for four cycles.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_hold = 4;
        release_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_addr", imem_addr, RST_PC);
        end
        @(negedge clk);
        #2;
        chk("accept_req_valid", imem_req_valid, 1);
        @(negedge clk);
        #2;
        chk("wait_entered", imem_req_valid, 0);
        wait_hs(2, 40, "stall_run");

        // Core stalls five cycles on an ebreak word.
        ovr_data = 32'h0010_0073;
        ovr_err  = 1'b0;
        ovr_hold = 5;
        ovr_en   = 1;
        wait_hs(2, 60, "core_stall");

        // Jump target taken on the next handshake.
        jump_pc = 32'h8000_0100;
        jump_en = 1;
        wait_hs(3, 60, "jump");

        // Bus error flagged then cleared.
        ovr_data = 32'hDEAD_BEEF;
        ovr_err  = 1'b1;
        ovr_hold = 2;
        ovr_en   = 1;
        wait_hs(2, 60, "bus_err");

`ifdef IFU_ALIGN_CHECK_EN
        jump_pc = 32'h8000_0002;
        jump_en = 1;
        wait_hs(3, 60, "misaligned");
        mis_rand = 1;
`endif

        // Randomized traffic on both sides.
        req_rand  = 1;
        core_rand = 1;
        jump_rand = 1;
        err_rand  = 1;
        lat_max   = 3;
        repeat (500) @(negedge clk);
        wait_hs(1, 100, "random_progress");

        // Asynchronous reset while a fetch is outstanding.
        req_rand  = 0;
        core_rand = 0;
        jump_rand = 0;
        err_rand  = 0;
        mis_rand  = 0;
        lat_min   = 6;
        lat_max   = 6;
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            #2;
            if (imem_req_valid && imem_req_ready) break;
            k++;
        end
        total++;
        if (k >= 60) begin
            bad++;
            $display("FAIL wait_accept: got no accepted request want one (timeout)");
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        lat_min = 0;
        lat_max = 0;
        release_reset();
        wait_hs(3, 40, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit feeding the single-cycle RV32 core. Holds the fetch PC, issues one read per instruction to instruction memory over a valid/ready request channel, and captures the response. It presents the instruction, with its PC, to the core's decode/execute stage through a valid/ready handshake. On acceptance it loads the core-computed next PC and starts the next fetch, so the core tolerates variable-latency instruction memory.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h8000_0000, PC after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  read address, equals current fetch PC
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  XLEN  instruction word
- imem_resp_err  in  1  bus error on this response
- inst_valid  out  1  inst/pc/inst_fault valid to core
- inst_ready  in  1  core consumes instruction this cycle
- inst  out  XLEN  instruction word
- pc  out  XLEN  PC of inst
- inst_fault  out  1  fetch error (bus error or misalignment)
- next_pc  in  XLEN  core's next PC, sampled only on inst_valid & inst_ready

## Operation
- States: IDLE, REQ, WAIT, VALID. Reset state IDLE.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> WAIT.
- WAIT: on imem_resp_valid, capture inst<=imem_resp_data and inst_fault<=imem_resp_err, then go to VALID.
- VALID: inst_valid=1. On inst_ready: pc<=next_pc, inst_fault<=0, go to REQ.
- imem_req_valid stays high in REQ until accepted. addr is stable while waiting.
- imem_resp_valid outside WAIT is ignored. This is a protocol violation and is flagged by a bench assertion.
- A response is never accepted in the same cycle as its request.
- inst/pc/inst_fault are held stable while inst_valid=1 and inst_ready=0.
- next_pc is used as-is. No alignment masking unless IFU_ALIGN_CHECK_EN is defined.
- rst_n asserted in any state: immediate return to IDLE with reset values. Any outstanding memory response is dropped. Memory must also be reset.

## Timing
- Reset values: imem_req_valid=0, imem_addr=RESET_PC, pc=RESET_PC, inst_valid=0, inst=32'h0000_0013, inst_fault=0.
- Minimum per-instruction latency is 3 cycles: REQ (ready=1), WAIT (resp=1), VALID (ready=1).
- Each memory stall cycle (req_ready=0 or resp_valid=0) adds one cycle. Each core stall cycle (inst_ready=0) adds one cycle.
- inst_valid rises the cycle after resp capture. The new imem_req_valid rises the cycle after inst handshake.
- All outputs come from registers or pure state decode. There is no combinational path from imem_* inputs to inst_* outputs.
- There is no combinational path from inst_ready to imem_req_valid.

## Configuration
- IFU_ALIGN_CHECK_EN defined:
  - In REQ, if pc[1:0]!=2'b00, no memory request is issued.
  - Next state is VALID with inst=32'h0000_0013 and inst_fault=1.
- IFU_ALIGN_CHECK_EN undefined:
  - No check is made. imem_addr=pc unmodified.
  - inst_fault reflects only imem_resp_err.

## Structure
- Package ifu_pkg holds:
  - state enum (IDLE, REQ, WAIT, VALID)
  - RESET_PC default
  - NOP constant 32'h0000_0013
- Flat module. No sub-module: the FSM and three holding registers (pc, inst, inst_fault) do not justify a split.
- The core's top instantiates ifu and connects pc_result to next_pc and inst_ready to its commit condition.

## Test plan
- Reset, memory always ready, 1-cycle response, core always ready: addr sequence 8000_0000, 8000_0004, 8000_0008, each inst_valid pulse 3 cycles apart.
- imem_req_ready held low 4 cycles in REQ: imem_addr stays 8000_0000 and valid stays high; WAIT entered only on the ready cycle.
- Response data 0x00100073 with inst_ready low 5 cycles: inst/pc stay stable throughout; pc advances only on the handshake cycle.
- next_pc=8000_0100 presented on handshake (jump): the next imem_addr is 8000_0100.
- imem_resp_err=1 with data 0xDEAD_BEEF: inst_fault=1 in VALID and clears after the handshake.
- IFU_ALIGN_CHECK_EN defined, next_pc=8000_0002: no imem_req_valid issued, inst=0x0000_0013, inst_fault=1.
- rst_n asserted in WAIT: all outputs return to reset values asynchronously; after release, fetch restarts at 8000_0000.
